debounce_sync: RTL and testbench



---
 rtl/debounce_sync_if.sv | 25 ++
 rtl/debounce_sync.sv | 72 +++++++
 tb/tb_debounce_sync.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/debounce_sync_if.sv
// Signal bundle between a raw asynchronous level source and the debouncer.
// The source drives d; the debouncer returns the clean level, edge pulses and busy.
interface debounce_sync_if;
    logic d;
    logic q;
    logic rise;
    logic fall;
    logic busy;

    modport master (
        output d,
        input  q,
        input  rise,
        input  fall,
        input  busy
    );

    modport slave (
        input  d,
        output q,
        output rise,
        output fall,
        output busy
    );
endinterface

// File: rtl/debounce_sync.sv
// Synchronizes a raw asynchronous level into clk, filters it with a stability
// counter and presents a registered clean level plus one-cycle rise/fall pulses.
module debounce_sync #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_MAX     = 4,
    parameter int CNT_W       = 16
) (
    input logic           clk,
    input logic           rst_n,
    debounce_sync_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic                   r_q;
    logic                   w_q_nxt;
    logic                   r_rise;
    logic                   w_rise_nxt;
    logic                   r_fall;
    logic                   w_fall_nxt;
    logic                   w_d_s;

    // Plain flop chain: no logic between stages so each flop can resolve.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], bus.d};
        end
    end

    assign w_d_s = r_sync[SYNC_STAGES-1];

    // A mismatch must persist CNT_MAX consecutive edges; any match discards the run.
    always_comb begin
        w_cnt_nxt  = r_cnt;
        w_q_nxt    = r_q;
        w_rise_nxt = 1'b0;
        w_fall_nxt = 1'b0;
        if (w_d_s == r_q) begin
            w_cnt_nxt = '0;
        end else if (r_cnt == CNT_LAST) begin
            w_q_nxt    = w_d_s;
            w_cnt_nxt  = '0;
            w_rise_nxt = w_d_s;
            w_fall_nxt = ~w_d_s;
        end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_q    <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_q    <= w_q_nxt;
            r_rise <= w_rise_nxt;
            r_fall <= w_fall_nxt;
        end
    end

    assign bus.q    = r_q;
    assign bus.rise = r_rise;
    assign bus.fall = r_fall;
    assign bus.busy = (r_cnt != '0);
endmodule

// File: tb/tb_debounce_sync.sv
// Bench for debounce_sync: default instance (CNT_MAX=4) and a CNT_MAX=1 instance
// share one d/rst_n; each edge's expected outputs come from a history-based model.
module tb_debounce_sync;
    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic d     = 1'b1;

    always #5 clk = ~clk;

    debounce_sync_if bus0 ();
    debounce_sync_if bus1 ();

    assign bus0.d = d;
    assign bus1.d = d;

    debounce_sync #(.SYNC_STAGES(2), .CNT_MAX(4), .CNT_W(16)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0.slave)
    );

    debounce_sync #(.SYNC_STAGES(2), .CNT_MAX(1), .CNT_W(16)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    // ---------------- scoreboard state ----------------
    int checks   = 0;
    int failures = 0;
    logic [3:0] exp_q0[$];
    logic [3:0] exp_q1[$];

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual={q,rise,fall,busy}=%b expected=%b at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // q flips to the synchronized value once the last CNT_MAX synchronized
    // samples taken since the previous commit all disagree with q.
    int  cm[2] = '{4, 1};
    bit  q_ref[2];
    int  last_commit[2];
    bit  samp[$];
    bit  ds_log[0:16383];
    int  n = 0;

    initial begin
        bit         ds;
        int         run;
        logic [3:0] e;
        repeat (2) samp.push_back(1'b0);
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                samp.delete();
                repeat (2) samp.push_back(1'b0);
                for (int i = 0; i < 2; i++) begin
                    q_ref[i]       = 1'b0;
                    last_commit[i] = n;
                end
                exp_q0.push_back(4'b0000);
                exp_q1.push_back(4'b0000);
            end else begin
                samp.push_back(d);
                ds = samp.pop_front();
                n++;
                ds_log[n] = ds;
                for (int i = 0; i < 2; i++) begin
                    run = 0;
                    for (int j = n; j > last_commit[i] && ds_log[j] != q_ref[i]; j--) run++;
                    e = 4'b0000;
                    if (run >= cm[i]) begin
                        q_ref[i]       = ds;
                        last_commit[i] = n;
                        e[2]           = ds;
                        e[1]           = ~ds;
                        run            = 0;
                    end
                    e[3] = q_ref[i];
                    e[0] = (run != 0);
                    if (i == 0) exp_q0.push_back(e);
                    else        exp_q1.push_back(e);
                end
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        logic [3:0] e;
        forever begin
            @(negedge clk);
            if (exp_q0.size() > 0) begin
                e = exp_q0.pop_front();
                check("dut0_out", {bus0.q, bus0.rise, bus0.fall, bus0.busy}, e);
            end
            if (exp_q1.size() > 0) begin
                e = exp_q1.pop_front();
                check("dut1_out", {bus1.q, bus1.rise, bus1.fall, bus1.busy}, e);
            end
        end
    end

    // Edge pulse tally for the bounce-train window.
    bit count_en = 1'b0;
    int rise_cnt = 0;
    int fall_cnt = 0;
    always @(negedge clk) begin
        if (count_en) begin
            rise_cnt += int'(bus0.rise);
            fall_cnt += int'(bus0.fall);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input bit v, input int cycles);
        for (int k = 0; k < cycles; k++) begin
            @(posedge clk);
            #2 d = v;
        end
    endtask

    task automatic pulse_reset(input int hold);
        @(posedge clk);
        #6 rst_n = 1'b0;
        repeat (hold) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // Reset held with d high, then released with d still high.
        d     = 1'b1;
        rst_n = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b1;
        drive(1'b1, 10);

        // Clean steps down and up.
        drive(1'b0, 10);
        drive(1'b1, 10);
        drive(1'b0, 10);

        // Glitch shorter than the stability window.
        drive(1'b1, 3);
        drive(1'b0, 10);

        // Bounce train then settle high.
        rise_cnt = 0;
        fall_cnt = 0;
        count_en = 1'b1;
        for (int k = 0; k < 20; k++) drive(k % 2 == 0, 1);
        drive(1'b1, 10);
        @(negedge clk);
        count_en = 1'b0;
        checks++;
        if (rise_cnt != 1) begin
            failures++;
            $display("FAIL bounce_rise_count actual=%0d expected=1", rise_cnt);
        end
        checks++;
        if (fall_cnt != 0) begin
            failures++;
            $display("FAIL bounce_fall_count actual=%0d expected=0", fall_cnt);
        end

        // Reset asserted mid-count, between E4 and E5.
        drive(1'b0, 10);
        drive(1'b1, 1);
        repeat (4) @(posedge clk);
        #6 rst_n = 1'b0;
        #1;
        check("midreset_dut0", {bus0.q, bus0.rise, bus0.fall, bus0.busy}, 4'b0000);
        check("midreset_dut1", {bus1.q, bus1.rise, bus1.fall, bus1.busy}, 4'b0000);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        drive(1'b1, 10);

        // Randomized runs with occasional resets.
        for (int s = 0; s < 150; s++) begin
            if ($urandom_range(0, 39) == 0) pulse_reset($urandom_range(1, 3));
            drive(1'($urandom_range(0, 1)), $urandom_range(1, 8));
        end
        drive(d, 10);

        repeat (2) @(negedge clk);
        checks++;
        if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d/%0d expected=0/0", exp_q0.size(), exp_q1.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
